// File: rtl/stand_sprite_fetch_if.sv
// Pixel, sprite-position, ROM and colour-mapper signals of the standing-sprite fetch unit.
// The master side drives pixel coordinates and ROM data, and the slave side is the fetch pipeline.
interface stand_sprite_fetch_if #(
  parameter int FW = 1
);
  logic [9:0]    DrawX;
  logic [9:0]    DrawY;
  logic [9:0]    sprite_x;
  logic [9:0]    sprite_y;
  logic          facing_left;
  logic          anim_en;
  logic [18:0]   stand_read_address;
  logic [4:0]    stand_data_in;
  logic          sprite_on;
  logic [4:0]    sprite_index;
  logic [FW-1:0] anim_frame;

  modport master (
    output DrawX, DrawY, sprite_x, sprite_y,
    output facing_left, anim_en, stand_data_in,
    input  stand_read_address, sprite_on,
    input  sprite_index, anim_frame
  );

  modport slave (
    input  DrawX, DrawY, sprite_x, sprite_y,
    input  facing_left, anim_en, stand_data_in,
    output stand_read_address, sprite_on,
    output sprite_index, anim_frame
  );
endinterface

// File: rtl/stand_sprite_fetch.sv
// Standing-sprite ROM address generator with mirroring, animation
// and a 3-stage pixel-alignment pipeline (ROM read included).
module stand_sprite_fetch #(
  parameter int         SPR_W       = 30,
  parameter int         SPR_H       = 45,
  parameter int         NUM_FRAMES  = 1,
  parameter int         FRAME_HOLD  = 8,
  parameter logic [4:0] TRANSPARENT = 5'h00
) (
  input logic Clk,
  input logic Reset_n,
  input logic frame_clk,
  stand_sprite_fetch_if.slave bus
);
  localparam int FW =
    (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HW =
    (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [18:0] FRAME_SZ =
    19'(SPR_W * SPR_H);
  localparam logic [18:0] W19 = 19'(SPR_W);
  localparam logic [10:0] W11 = 11'(SPR_W);
  localparam logic [10:0] H11 = 11'(SPR_H);
  localparam logic [9:0]  WM1 = 10'(SPR_W - 1);
  localparam logic [FW-1:0] F_LAST =
    FW'(NUM_FRAMES - 1);
  localparam logic [HW-1:0] H_LAST =
    HW'(FRAME_HOLD - 1);

  logic [FW-1:0] frame_q;
  logic [HW-1:0] hold_q;
  logic          fclk_d;
  logic          rise;

  logic [10:0] dx11, dy11, sx11, sy11;
  logic        in_box;
  logic [9:0]  col, row, colm;
  logic [18:0] addr_nxt;
  logic [18:0] addr_q;
  logic        in_box_d1, in_box_d2;
  logic        on_nxt;
  logic        on_q;
  logic [4:0]  idx_q;

  // 11-bit compares so a sprite near the right edge does not wrap
  always_comb begin
    dx11   = {1'b0, bus.DrawX};
    dy11   = {1'b0, bus.DrawY};
    sx11   = {1'b0, bus.sprite_x};
    sy11   = {1'b0, bus.sprite_y};
    in_box = (dx11 >= sx11) && (dx11 < sx11 + W11)
          && (dy11 >= sy11) && (dy11 < sy11 + H11);
    col  = bus.DrawX - bus.sprite_x;
    row  = bus.DrawY - bus.sprite_y;
    colm = bus.facing_left ? (WM1 - col) : col;
    addr_nxt = '0;
    if (in_box) begin
      addr_nxt = 19'(frame_q) * FRAME_SZ
               + 19'(row) * W19
               + 19'(colm);
    end
    on_nxt = in_box_d2
          && (bus.stand_data_in != TRANSPARENT);
    rise = frame_clk && !fclk_d;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      addr_q    <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
      on_q      <= 1'b0;
      idx_q     <= '0;
    end else begin
      addr_q    <= addr_nxt;
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
      on_q      <= on_nxt;
      idx_q     <= on_nxt ? bus.stand_data_in : 5'd0;
    end
  end

  // Delay reg resets high so a high frame_clk at release is not an edge
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fclk_d  <= 1'b1;
      hold_q  <= '0;
      frame_q <= '0;
    end else begin
      fclk_d <= frame_clk;
      if (rise) begin
        if (!bus.anim_en) begin
          hold_q  <= '0;
          frame_q <= '0;
        end else if (hold_q == H_LAST) begin
          hold_q  <= '0;
          frame_q <= (frame_q == F_LAST)
                   ? '0 : frame_q + 1'b1;
        end else begin
          hold_q <= hold_q + 1'b1;
        end
      end
    end
  end

  assign bus.stand_read_address = addr_q;
  assign bus.sprite_on          = on_q;
  assign bus.sprite_index       = idx_q;
  assign bus.anim_frame         = frame_q;
endmodule

// File: tb/tb_stand_sprite_fetch.sv
// Self-checking bench for stand_sprite_fetch with a registered ROM model
// and a coordinate-level reference model of address and pixel output.
module tb_stand_sprite_fetch;
  localparam int W  = 30;
  localparam int H  = 45;
  localparam int NF = 3;
  localparam int FH = 2;
  localparam int N  = 300;

  logic Clk = 1'b0;
  logic Reset_n;
  logic frame_clk;
  logic       rom_ov;
  logic [4:0] rom_val;
  logic [4:0] rom_q;

  int checks = 0;
  int errors = 0;

  stand_sprite_fetch_if #(.FW(2)) bus ();

  stand_sprite_fetch #(
    .SPR_W(W), .SPR_H(H),
    .NUM_FRAMES(NF), .FRAME_HOLD(FH),
    .TRANSPARENT(5'h00)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_clk(frame_clk),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  always_ff @(posedge Clk)
    rom_q <= rom_ov ? rom_val
                    : bus.stand_read_address[4:0];
  assign bus.stand_data_in = rom_q;

  function automatic bit m_in(int dx, int dy,
                              int sx, int sy);
    return dx >= sx && dx < sx + W
        && dy >= sy && dy < sy + H;
  endfunction

  function automatic int m_addr(int dx, int dy,
      int sx, int sy, bit fl, int fr);
    int c;
    if (!m_in(dx, dy, sx, sy)) return 0;
    c = dx - sx;
    if (fl) c = W - 1 - c;
    return fr * W * H + (dy - sy) * W + c;
  endfunction

  task automatic set_px(int sx, int sy, int dx,
                        int dy, bit fl);
    bus.sprite_x    = 10'(sx);
    bus.sprite_y    = 10'(sy);
    bus.DrawX       = 10'(dx);
    bus.DrawY       = 10'(dy);
    bus.facing_left = fl;
  endtask

  task automatic run_px(input int sx, input int sy,
      input int dx, input int dy, input bit fl,
      input bit ov, input logic [4:0] d,
      output int a, output bit on,
      output int idx);
    @(negedge Clk);
    set_px(sx, sy, dx, dy, fl);
    rom_ov  = ov;
    rom_val = d;
    @(posedge Clk); #1;
    a = int'(bus.stand_read_address);
    @(posedge Clk);
    @(posedge Clk); #1;
    on  = bus.sprite_on;
    idx = int'(bus.sprite_index);
  endtask

  task automatic pulse();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (5) @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    rom_ov  = 1'b1;
    rom_val = 5'h07;
    set_px(100, 50, 103, 52, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      frame_clk = ~frame_clk;
      @(posedge Clk); #1;
      checks++;
      if (bus.stand_read_address !== 19'd0
          || bus.sprite_on !== 1'b0
          || bus.sprite_index !== 5'd0
          || bus.anim_frame !== 2'd0) begin
        errors++;
        $display("FAIL reset_state addr=%0d on=%b idx=%0d fr=%0d want 0",
          bus.stand_read_address, bus.sprite_on,
          bus.sprite_index, bus.anim_frame);
      end
    end
    @(negedge Clk);
    Reset_n   = 1'b1;
    frame_clk = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge Clk); #1;
      checks++;
      if (bus.sprite_on !== (e == 3)) begin
        errors++;
        $display("FAIL reset_release edge%0d on=%b want %b",
          e, bus.sprite_on, e == 3);
      end
    end
  endtask

  task automatic test_basic();
    int a, idx;
    bit on;
    int wa;
    for (int f = 0; f < 2; f++) begin
      wa = m_addr(103, 52, 100, 50, f[0], 0);
      run_px(100, 50, 103, 52, f[0], 1'b1, 5'h07,
             a, on, idx);
      checks++;
      if (a !== wa) begin
        errors++;
        $display("FAIL addr_fl%0d got %0d want %0d",
          f, a, wa);
      end
      checks++;
      if (on !== 1'b1 || idx !== 7) begin
        errors++;
        $display("FAIL pix_fl%0d on=%b idx=%0d want 1/7",
          f, on, idx);
      end
    end
  endtask

  task automatic test_edges();
    int sx[5] = '{100, 100, 100, 100, 1000};
    int dx[5] = '{129, 130,  99, 110, 1023};
    int dy[5] = '{ 52,  52,  52,  95,   52};
    int a, idx, wa;
    bit on, win;
    for (int i = 0; i < 5; i++) begin
      win = m_in(dx[i], dy[i], sx[i], 50);
      wa  = m_addr(dx[i], dy[i], sx[i], 50, 1'b0, 0);
      run_px(sx[i], 50, dx[i], dy[i], 1'b0,
             1'b1, 5'h1F, a, on, idx);
      checks++;
      if (a !== wa || on !== win
          || idx !== (win ? 31 : 0)) begin
        errors++;
        $display("FAIL edge%0d addr=%0d on=%b idx=%0d want %0d/%b/%0d",
          i, a, on, idx, wa, win, win ? 31 : 0);
      end
    end
  endtask

  task automatic test_transparent();
    int a, idx;
    bit on;
    run_px(100, 50, 110, 60, 1'b0, 1'b1, 5'h00,
           a, on, idx);
    checks++;
    if (on !== 1'b0 || idx !== 0) begin
      errors++;
      $display("FAIL transparent on=%b idx=%0d want 0/0",
        on, idx);
    end
    run_px(100, 50, 110, 60, 1'b0, 1'b1, 5'h1F,
           a, on, idx);
    checks++;
    if (on !== 1'b1 || idx !== 31) begin
      errors++;
      $display("FAIL opaque_1f on=%b idx=%0d want 1/31",
        on, idx);
    end
  endtask

  task automatic test_random_stream();
    int ea[N];
    bit eon[N];
    int eidx[N];
    int sx, sy, dx, dy;
    bit fl;
    rom_ov = 1'b0;
    for (int i = 0; i < N + 3; i++) begin
      @(negedge Clk);
      if (i >= 1 && i <= N) begin
        checks++;
        if (int'(bus.stand_read_address) !== ea[i-1]) begin
          errors++;
          $display("FAIL rnd_addr[%0d] got %0d want %0d",
            i - 1, bus.stand_read_address, ea[i-1]);
        end
      end
      if (i >= 3) begin
        checks++;
        if (bus.sprite_on !== eon[i-3]
            || int'(bus.sprite_index) !== eidx[i-3]) begin
          errors++;
          $display("FAIL rnd_pix[%0d] on=%b idx=%0d want %b/%0d",
            i - 3, bus.sprite_on, bus.sprite_index,
            eon[i-3], eidx[i-3]);
        end
      end
      if (i < N) begin
        sx = int'($urandom_range(0, 1023));
        sy = int'($urandom_range(0, 1023));
        dx = (sx + int'($urandom_range(0, 40)) - 5) % 1024;
        dy = (sy + int'($urandom_range(0, 55)) - 5) % 1024;
        if (dx < 0) dx += 1024;
        if (dy < 0) dy += 1024;
        fl = 1'($urandom);
        set_px(sx, sy, dx, dy, fl);
        ea[i]   = m_addr(dx, dy, sx, sy, fl, 0);
        eon[i]  = m_in(dx, dy, sx, sy)
               && (ea[i] % 32) != 0;
        eidx[i] = eon[i] ? ea[i] % 32 : 0;
      end
    end
  endtask

  task automatic test_anim();
    int a, idx, wf;
    bit on;
    bus.anim_en = 1'b1;
    for (int p = 1; p <= 6; p++) begin
      pulse();
      wf = (p / FH) % NF;
      checks++;
      if (int'(bus.anim_frame) !== wf) begin
        errors++;
        $display("FAIL anim_p%0d frame=%0d want %0d",
          p, bus.anim_frame, wf);
      end
      if (p == 4) begin
        run_px(200, 100, 200, 100, 1'b0, 1'b0,
               5'h00, a, on, idx);
        checks++;
        if (a !== m_addr(200, 100, 200, 100, 1'b0, wf)) begin
          errors++;
          $display("FAIL anim_addr got %0d want %0d",
            a, m_addr(200, 100, 200, 100, 1'b0, wf));
        end
      end
    end
    pulse();
    pulse();
    bus.anim_en = 1'b0;
    pulse();
    checks++;
    if (bus.anim_frame !== 2'd0) begin
      errors++;
      $display("FAIL anim_off frame=%0d want 0",
        bus.anim_frame);
    end
  endtask

  initial begin
    frame_clk   = 1'b0;
    bus.anim_en = 1'b0;
    test_reset();
    test_basic();
    test_edges();
    test_transparent();
    test_random_stream();
    test_anim();
    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end
endmodule
